// File: rtl/riscv_mem_arbiter.sv
// Arbitrates I-cache refills and D-cache refill/writeback onto one DRAM port, round-robin on contention.
// Latency: strobe 1 cycle after request; ready is combinational from DRAM ready; one IDLE cycle between transactions.
// Backpressure: requesters hold rden/wren until their ready pulse; the latched transaction ignores later request changes.
module riscv_mem_arbiter #(
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10
) (
    input  logic                  i_riscv_arb_clk,
    input  logic                  i_riscv_arb_rst,
    input  logic                  i_riscv_arb_imem_rden,
    input  logic [S_ADDR-1:0]     i_riscv_arb_imem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_imem_data_out,
    output logic                  o_riscv_arb_imem_ready,
    input  logic                  i_riscv_arb_dmem_rden,
    input  logic                  i_riscv_arb_dmem_wren,
    input  logic [S_ADDR-1:0]     i_riscv_arb_dmem_addr,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_dmem_data_in,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_dmem_data_out,
    output logic                  o_riscv_arb_dmem_ready,
    output logic                  o_riscv_arb_mem_rden,
    output logic                  o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]     o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0] o_riscv_arb_mem_data_in,
    input  logic [DATA_WIDTH-1:0] i_riscv_arb_mem_data_out,
    input  logic                  i_riscv_arb_mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    last_d;     // 1 when the D port completed the most recent transaction
    logic                    grant_d;
    logic                    d_req;
    logic                    lat_wr;
    logic [S_ADDR-1:0]       lat_addr;
    logic [DATA_WIDTH-1:0]   lat_data;

    assign d_req = i_riscv_arb_dmem_rden | i_riscv_arb_dmem_wren;

    always_ff @(posedge i_riscv_arb_clk) begin
        if (i_riscv_arb_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        case (state)
            IDLE: begin
                if (i_riscv_arb_imem_rden && d_req) begin
                    grant_d   = ~last_d;
                    state_nxt = last_d ? BUSY_I : BUSY_D;
                end else if (i_riscv_arb_imem_rden) begin
                    state_nxt = BUSY_I;
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (i_riscv_arb_mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction is captured only on leaving IDLE, so requesters may change inputs freely while busy.
    always_ff @(posedge i_riscv_arb_clk) begin
        if (i_riscv_arb_rst) begin
            last_d   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_addr <= '0;
            lat_data <= '0;
        end else begin
            if (state == IDLE && state_nxt != IDLE) begin
                lat_addr <= grant_d ? i_riscv_arb_dmem_addr : i_riscv_arb_imem_addr;
                lat_data <= grant_d ? i_riscv_arb_dmem_data_in : '0;
                lat_wr   <= grant_d & i_riscv_arb_dmem_wren;
            end
            if (state != IDLE && i_riscv_arb_mem_ready) begin
                last_d <= (state == BUSY_D);
            end
        end
    end

    // Reset gating keeps a DRAM ready that lands in the reset cycle from reaching either cache.
    always_comb begin
        o_riscv_arb_mem_rden   = 1'b0;
        o_riscv_arb_mem_wren   = 1'b0;
        o_riscv_arb_imem_ready = 1'b0;
        o_riscv_arb_dmem_ready = 1'b0;
        if (!i_riscv_arb_rst) begin
            case (state)
                BUSY_I: begin
                    o_riscv_arb_mem_rden   = ~lat_wr;
                    o_riscv_arb_mem_wren   = lat_wr;
                    o_riscv_arb_imem_ready = i_riscv_arb_mem_ready;
                end
                BUSY_D: begin
                    o_riscv_arb_mem_rden   = ~lat_wr;
                    o_riscv_arb_mem_wren   = lat_wr;
                    o_riscv_arb_dmem_ready = i_riscv_arb_mem_ready;
                end
                default: ;
            endcase
        end
    end

    assign o_riscv_arb_mem_addr      = lat_addr;
    assign o_riscv_arb_mem_data_in   = lat_data;
    assign o_riscv_arb_imem_data_out = i_riscv_arb_mem_data_out;
    assign o_riscv_arb_dmem_data_out = i_riscv_arb_mem_data_out;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Bench for riscv_mem_arbiter: random I/D cache traffic against a DRAM model, round-robin grant model and response scoreboard.
module tb_riscv_mem_arbiter;
    localparam int DW = 128;
    localparam int AW = 10;

    logic          clk;
    logic          rst;
    logic          imem_rden;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data_out;
    logic          imem_ready;
    logic          dmem_rden;
    logic          dmem_wren;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_data_in;
    logic [DW-1:0] dmem_data_out;
    logic          dmem_ready;
    logic          mem_rden;
    logic          mem_wren;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_ready;

    riscv_mem_arbiter #(.DATA_WIDTH(DW), .S_ADDR(AW)) dut (
        .i_riscv_arb_clk           (clk),
        .i_riscv_arb_rst           (rst),
        .i_riscv_arb_imem_rden     (imem_rden),
        .i_riscv_arb_imem_addr     (imem_addr),
        .o_riscv_arb_imem_data_out (imem_data_out),
        .o_riscv_arb_imem_ready    (imem_ready),
        .i_riscv_arb_dmem_rden     (dmem_rden),
        .i_riscv_arb_dmem_wren     (dmem_wren),
        .i_riscv_arb_dmem_addr     (dmem_addr),
        .i_riscv_arb_dmem_data_in  (dmem_data_in),
        .o_riscv_arb_dmem_data_out (dmem_data_out),
        .o_riscv_arb_dmem_ready    (dmem_ready),
        .o_riscv_arb_mem_rden      (mem_rden),
        .o_riscv_arb_mem_wren      (mem_wren),
        .o_riscv_arb_mem_addr      (mem_addr),
        .o_riscv_arb_mem_data_in   (mem_data_in),
        .i_riscv_arb_mem_data_out  (mem_data_out),
        .i_riscv_arb_mem_ready     (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          rd;
        logic [DW-1:0] data;
    } dexp_t;

    int            chk_cnt = 0;
    int            pass_cnt = 0;
    int            i_rdy_cnt = 0;
    int            d_rdy_cnt = 0;
    logic [DW-1:0] dram    [1024];
    logic [DW-1:0] ref_mem [1024];
    logic [DW-1:0] i_q[$];
    dexp_t         d_q[$];
    bit            order[$];
    int            dram_lat = -1;
    bit            dram_en = 1'b1;

    // monitor state: round-robin model and pending grant prediction
    bit            m_after_done = 1'b0;
    bit            m_pend = 1'b0;
    bit            m_last_d = 1'b0;
    logic [AW-1:0] m_addr;
    logic          m_wr;
    logic [DW-1:0] m_data;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic i_txn(input logic [AW-1:0] a);
        int n = 0;
        imem_rden = 1'b1;
        imem_addr = a;
        i_q.push_back(ref_mem[a]);
        do begin
            @(negedge clk);
            n++;
        end while (!imem_ready && n < 60);
        check("i_done", imem_ready, 1);
        @(posedge clk); #1;
        imem_rden = 1'b0;
    endtask

    task automatic d_txn(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        dmem_wren    = wr;
        dmem_rden    = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        dmem_addr    = a;
        dmem_data_in = d;
        if (wr) begin
            ref_mem[a] = d;
            d_q.push_back('{1'b0, '0});
        end else begin
            d_q.push_back('{1'b1, ref_mem[a]});
        end
        do begin
            @(negedge clk);
            n++;
        end while (!dmem_ready && n < 60);
        check("d_done", dmem_ready, 1);
        @(posedge clk); #1;
        dmem_rden = 1'b0;
        dmem_wren = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // DRAM model: answers each strobe after dram_lat (or random 0..3) extra cycles
    initial begin
        int cnt = 0;
        bit busy = 1'b0;
        mem_ready    = 1'b0;
        mem_data_out = '0;
        forever begin
            @(posedge clk); #1;
            if (!dram_en) continue;
            mem_ready = 1'b0;
            if (mem_rden || mem_wren) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt  = (dram_lat < 0) ? int'($urandom_range(0, 3)) : dram_lat;
                end
                if (cnt == 0) begin
                    mem_ready    = 1'b1;
                    mem_data_out = mem_rden ? dram[mem_addr] : rnd_blk();
                    if (mem_wren) dram[mem_addr] = mem_data_in;
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [DW-1:0] ie;
        dexp_t         de;
        bit            gd;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_after_done = 1'b0;
                m_pend       = 1'b0;
                m_last_d     = 1'b0;
                continue;
            end
            if (m_pend) begin
                check("grant_addr", mem_addr, m_addr);
                check("grant_op", {mem_wren, mem_rden}, m_wr ? 2'b10 : 2'b01);
                if (m_wr) check("grant_wdata", mem_data_in, m_data);
                m_pend = 1'b0;
            end
            if (m_after_done) check("idle_gap", {mem_rden, mem_wren}, 0);
            if (imem_ready) begin
                i_rdy_cnt++;
                order.push_back(1'b0);
                m_last_d = 1'b0;
                check("i_excl", dmem_ready, 0);
                check("i_mirror", imem_data_out, mem_data_out);
                check("i_expected", i_q.size() != 0, 1);
                if (i_q.size() != 0) begin
                    ie = i_q.pop_front();
                    check("i_rdata", imem_data_out, ie);
                end
            end
            if (dmem_ready) begin
                d_rdy_cnt++;
                order.push_back(1'b1);
                m_last_d = 1'b1;
                check("d_excl", imem_ready, 0);
                check("d_mirror", dmem_data_out, mem_data_out);
                check("d_expected", d_q.size() != 0, 1);
                if (d_q.size() != 0) begin
                    de = d_q.pop_front();
                    if (de.rd) check("d_rdata", dmem_data_out, de.data);
                end
            end
            m_after_done = imem_ready | dmem_ready;
            if (!mem_rden && !mem_wren && (imem_rden || dmem_rden || dmem_wren)) begin
                gd     = (dmem_rden || dmem_wren) && (!imem_rden || !m_last_d);
                m_pend = 1'b1;
                m_addr = gd ? dmem_addr : imem_addr;
                m_wr   = gd && dmem_wren;
                m_data = dmem_data_in;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        int  i0;
        int  d0;
        bit  exp_ord[4];
        int  n;
        exp_ord = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 1024; k++) begin
            dram[k]    = rnd_blk();
            ref_mem[k] = dram[k];
        end
        rst          = 1'b1;
        imem_rden    = 1'b1;
        imem_addr    = 10'h3ff;
        dmem_rden    = 1'b0;
        dmem_wren    = 1'b1;
        dmem_addr    = 10'h155;
        dmem_data_in = rnd_blk();

        // reset state, with requests asserted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {mem_rden, mem_wren}, 0);
        check("rst_ready", {imem_ready, dmem_ready}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_data_in, 0);
        @(posedge clk); #1;
        rst       = 1'b0;
        imem_rden = 1'b0;
        dmem_wren = 1'b0;

        // spurious DRAM ready in IDLE
        dram_en   = 1'b0;
        mem_ready = 1'b1;
        i0 = i_rdy_cnt;
        d0 = d_rdy_cnt;
        @(negedge clk);
        check("spur_ready", {imem_ready, dmem_ready}, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("spur_strobes", {mem_rden, mem_wren}, 0);
        dram_en = 1'b1;
        @(posedge clk); #1;

        // single I read, DRAM answers after 3 cycles
        dram_lat = 3;
        i0 = i_rdy_cnt;
        d0 = d_rdy_cnt;
        i_txn(10'h012);
        repeat (2) @(negedge clk);
        check("single_i_cnt", i_rdy_cnt - i0, 1);
        check("single_d_cnt", d_rdy_cnt - d0, 0);
        @(posedge clk); #1;

        // simultaneous I read and D write: D first (last grant is I)
        dram_lat = 1;
        order.delete();
        fork
            i_txn(10'h004);
            d_txn(1'b1, 10'h008, {16{8'hA5}});
        join
        check("simul_n", order.size(), 2);
        if (order.size() == 2) begin
            check("simul_first", order[0], 1);
            check("simul_second", order[1], 0);
        end

        // back-to-back contention
        dram_lat = -1;
        order.delete();
        fork
            begin
                repeat (2) i_txn(10'($urandom_range(0, 511)));
            end
            begin
                repeat (2) d_txn(1'b0, 10'($urandom_range(512, 1023)), '0);
            end
        join
        check("rr_n", order.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < order.size()) check("rr_order", order[k], exp_ord[k]);
        end

        // D request dropped and address changed while busy
        dram_lat  = 4;
        d0        = d_rdy_cnt;
        dmem_rden = 1'b1;
        dmem_addr = 10'h300;
        d_q.push_back('{1'b1, ref_mem[10'h300]});
        @(posedge clk); #1;
        @(posedge clk); #1;
        dmem_rden = 1'b0;
        dmem_addr = 10'h155;
        n = 0;
        do begin
            @(negedge clk);
            check("hold_addr", mem_addr, 10'h300);
            n++;
        end while (!dmem_ready && n < 20);
        check("hold_done", d_rdy_cnt - d0, 1);
        @(posedge clk); #1;

        // randomized traffic
        dram_lat = -1;
        fork
            begin
                for (int t = 0; t < 30; t++) begin
                    int gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    i_txn(10'($urandom_range(0, 511)));
                end
            end
            begin
                for (int t = 0; t < 30; t++) begin
                    int gap = $urandom_range(0, 3);
                    if (gap > 0) begin
                        repeat (gap) @(posedge clk);
                        #1;
                    end
                    d_txn(1'($urandom_range(0, 1)), 10'($urandom_range(512, 1023)), rnd_blk());
                end
            end
        join
        repeat (3) @(negedge clk);
        check("i_q_empty", i_q.size(), 0);
        check("d_q_empty", d_q.size(), 0);

        // reset while BUSY_I waits for DRAM
        @(posedge clk); #1;
        dram_en   = 1'b0;
        mem_ready = 1'b0;
        i0        = i_rdy_cnt;
        imem_rden = 1'b1;
        imem_addr = 10'h020;
        @(posedge clk); #1;
        @(posedge clk); #1;
        imem_rden = 1'b0;
        @(negedge clk);
        check("busy_strobe", mem_rden, 1);
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("midrst_ready", {imem_ready, dmem_ready}, 0);
        check("midrst_strobes", {mem_rden, mem_wren}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("postrst_ready", {imem_ready, dmem_ready}, 0);
        check("postrst_strobes", {mem_rden, mem_wren}, 0);
        check("postrst_addr", mem_addr, 0);
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(negedge clk);
        check("postrst_idle", {mem_rden, mem_wren}, 0);
        check("postrst_no_i", i_rdy_cnt - i0, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 128: width of one cache block in bits.
REQ-002 Parameter S_ADDR, default 10: width of the block address (byte offset removed).
REQ-003 i_riscv_arb_clk  in  1  single clock; all state updates on the rising edge.
REQ-004 i_riscv_arb_rst  in  1  reset, synchronous, active-high.
REQ-005 i_riscv_arb_imem_rden  in  1  I-cache refill read request.
REQ-006 i_riscv_arb_imem_addr  in  S_ADDR  I-cache block address.
REQ-007 o_riscv_arb_imem_data_out  out  DATA_WIDTH  read block returned to the I-cache.
REQ-008 o_riscv_arb_imem_ready  out  1  one-cycle completion pulse to the I-cache.
REQ-009 i_riscv_arb_dmem_rden  in  1  D-cache refill read request.
REQ-010 i_riscv_arb_dmem_wren  in  1  D-cache writeback request.
REQ-011 i_riscv_arb_dmem_addr  in  S_ADDR  D-cache block address.
REQ-012 i_riscv_arb_dmem_data_in  in  DATA_WIDTH  writeback block.
REQ-013 o_riscv_arb_dmem_data_out  out  DATA_WIDTH  read block returned to the D-cache.
REQ-014 o_riscv_arb_dmem_ready  out  1  one-cycle completion pulse to the D-cache.
REQ-015 o_riscv_arb_mem_rden / o_riscv_arb_mem_wren  out  1 each  strobes to the shared DRAM model.
REQ-016 o_riscv_arb_mem_addr  out  S_ADDR  DRAM block address.
REQ-017 o_riscv_arb_mem_data_in  out  DATA_WIDTH  DRAM write data.
REQ-018 i_riscv_arb_mem_data_out  in  DATA_WIDTH  DRAM read data.
REQ-019 i_riscv_arb_mem_ready  in  1  DRAM completion pulse.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY_I, BUSY_D.
REQ-021 In IDLE with only imem_rden high, the next state SHALL be BUSY_I.
REQ-022 In IDLE with only dmem_rden or dmem_wren high, the next state SHALL be BUSY_D.
REQ-023 When both ports request in IDLE, the grant SHALL go to the port not granted last (round-robin), using a 1-bit last-grant register that is reset to I.
REQ-024 On the IDLE-to-BUSY edge, the arbiter SHALL latch the granted port's address, write data and operation into registers; the mem_* outputs SHALL be driven only from these registers.
REQ-025 In a BUSY state, o_riscv_arb_mem_rden or o_riscv_arb_mem_wren (as latched) SHALL be held high continuously until i_riscv_arb_mem_ready is sampled high.
REQ-026 If dmem_rden and dmem_wren are both high, the arbiter SHALL perform a write.
REQ-027 While BUSY_x, ready_x SHALL equal i_riscv_arb_mem_ready combinationally, and the other port's ready SHALL be 0.
REQ-028 Both data_out ports SHALL carry i_riscv_arb_mem_data_out unconditionally.
REQ-029 When mem_ready is sampled in BUSY_x, the next state SHALL be IDLE and the strobes SHALL be 0 in the following cycle.
REQ-030 The last-grant register SHALL update on completion.
REQ-031 Minimum latency from request to strobe SHALL be 1 cycle.
REQ-032 There SHALL be one mandatory IDLE cycle between transactions.
REQ-033 Requests arriving or dropping during BUSY SHALL NOT alter the latched transaction; a granted transaction always runs to mem_ready.
REQ-034 mem_ready sampled in IDLE SHALL be ignored: no port ready, no state change.
REQ-035 Neither port SHALL wait more than one other-port transaction while requesting continuously (no starvation).

Reset
REQ-036 While reset is high, the following SHALL hold: state IDLE, both mem strobes 0, both ready outputs 0, latched address and data 0, last-grant = I.
REQ-037 Reset asserted mid-transaction SHALL abandon the transaction, with no ready pulse delivered to either port in the cycle after reset.

Verification
REQ-038 Single I read: imem_rden with addr 0x012 in IDLE -> mem_rden=1 and mem_addr=0x012 next cycle; DRAM ready after 3 cycles -> imem_ready pulses once with that data; dmem_ready stays 0.
REQ-039 Simultaneous requests after reset: I read 0x004 and D write 0x008 (data 0xA5..A5) -> D write served first, then I read after one IDLE cycle; mem_data_in=0xA5..A5 during the write.
REQ-040 Back-to-back contention: both ports requesting continuously for 4 transactions -> grants alternate D, I, D, I.
REQ-041 D request dropped and address changed during BUSY_D -> mem_addr holds the original value until mem_ready.
REQ-042 Spurious mem_ready in IDLE -> no ready to either port, state stays IDLE.
REQ-043 Reset pulsed while BUSY_I waits for mem_ready -> strobes 0 and state IDLE in the next cycle; no imem_ready pulse.
